// File: rtl/fifo_burst_packer_if.sv
// Bundles the FIFO read-side signals and the burst write-data handshake.
// The master modport is the packer's view; slave is the FIFO/downstream side.
interface fifo_burst_packer_if #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 8,
  parameter int DEPTH_P2  = 5
);
  logic [WIDTH-1:0]           fifo_data;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       fifo_put;
  logic [DEPTH_P2:0]          fifo_fillcount;
  logic                       fifo_get;
  logic                       flush;
  logic [WIDTH*BURST_LEN-1:0] burst_data;
  logic [BURST_LEN-1:0]       burst_mask;
  logic                       burst_valid;
  logic                       burst_ready;
  logic                       flush_done;

  modport master (
    input  fifo_data, fifo_empty, fifo_full, fifo_put, fifo_fillcount, flush, burst_ready,
    output fifo_get, burst_data, burst_mask, burst_valid, flush_done
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_full, fifo_put, fifo_fillcount, flush, burst_ready,
    input  fifo_get, burst_data, burst_mask, burst_valid, flush_done
  );
endinterface

// File: rtl/fifo_burst_packer.sv
// Drains FIFO entries and packs BURST_LEN of them into one burst word with a lane mask;
// flush forces out a partial burst. Burst is held under valid/ready until accepted.
module fifo_burst_packer #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 8,
  parameter int DEPTH_P2  = 5
) (
  input logic                 clk,
  input logic                 reset,
  fifo_burst_packer_if.master bus
);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int LANE_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [DEPTH_P2:0]   FULL_CNT  = (DEPTH_P2 + 1)'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

  state_t                     state, state_nxt;
  logic [BEAT_W-1:0]          beat;
  logic [LANE_W-1:0]          lane;
  logic                       flush_pend;
  logic                       flush_done_q;
  logic [WIDTH*BURST_LEN-1:0] data_q;
  logic [BURST_LEN-1:0]       mask_q;
  logic                       get;
  logic                       pop;
  logic                       accept;
  logic                       pend_clear;

  assign get    = (state == COLLECT);
  // The FIFO gives a simultaneous put priority, so a get during a put is ignored.
  assign pop    = get & ~bus.fifo_empty & ~(bus.fifo_put & ~bus.fifo_full);
  assign accept = (state == PRESENT) & bus.burst_ready;
  assign lane   = beat[LANE_W-1:0];

  assign bus.fifo_get    = get;
  assign bus.burst_valid = (state == PRESENT);
  assign bus.burst_data  = data_q;
  assign bus.burst_mask  = mask_q;
  assign bus.flush_done  = flush_done_q;

  always_comb begin
    state_nxt  = state;
    pend_clear = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fifo_fillcount >= FULL_CNT || (flush_pend && !bus.fifo_empty))
          state_nxt = COLLECT;
        else if (flush_pend)
          pend_clear = 1'b1;
      end
      COLLECT: begin
        if (pop && beat == LAST_BEAT)
          state_nxt = PRESENT;
        else if (!pop && bus.fifo_empty && flush_pend && beat != '0)
          state_nxt = PRESENT;
      end
      PRESENT: begin
        if (bus.burst_ready) begin
          state_nxt  = IDLE;
          pend_clear = flush_pend & bus.fifo_empty;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      flush_pend   <= 1'b0;
      flush_done_q <= 1'b0;
      data_q       <= '0;
      mask_q       <= '0;
    end else begin
      state        <= state_nxt;
      flush_done_q <= pend_clear;
      // A new flush arriving on the clearing edge stays pending for the next pass.
      if (bus.flush)
        flush_pend <= 1'b1;
      else if (pend_clear)
        flush_pend <= 1'b0;
      if (pop) begin
        data_q[lane*WIDTH +: WIDTH] <= bus.fifo_data;
        mask_q[lane]                <= 1'b1;
        beat                        <= beat + BEAT_W'(1);
      end
      if (accept) begin
        data_q <= '0;
        mask_q <= '0;
        beat   <= '0;
      end
    end
  end
endmodule
